mem_arbiter: RTL and testbench

- Two-requester arbiter/sequencer in front of the shared 128-byte, big-endian, 16-bit-word data memory.
- Port 0 is the instruction-fetch side (read-only); port 1 is the load/store side (read/write).
- Serialises requests onto the memory's single port (memRead, memWrite, address, dataIn, dataOut) with round-robin fairness, range checking and a per-port response handshake.

---
 rtl/mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// Port 0 is instruction fetch (read-only); port 1 is load/store. One access every two cycles at most.

module mem_arbiter #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int MEM_BYTES = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   output logic              ready0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   output logic              err0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ready1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic              err1,
   output logic              memRead,
   output logic              memWrite,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] dataIn,
   input  logic [DATA_W-1:0] dataOut
);

   localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 2);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rvalid0_q, rvalid0_d;
   logic              rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              err0_q, err0_d;
   logic              err1_q, err1_d;
   logic              grant0, grant1;
   logic              illegal;

   assign illegal = (addr_q > MAX_ADDR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant0 || grant1) state_d = ACCESS;
         ACCESS:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready0   = 1'b0;
      ready1   = 1'b0;
      memRead  = 1'b0;
      memWrite = 1'b0;
      address  = addr_q;
      dataIn   = wdata_q;
      case (state_q)
         IDLE: begin
            ready0 = grant0;
            ready1 = grant1;
         end
         ACCESS: begin
            if (!illegal) begin
               memRead  = !we_q;
               memWrite = we_q;
            end
         end
         default: ;
      endcase
   end

   // Under contention the port that did not win last time is granted.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == IDLE) begin
         if (req0 && req1) begin
            grant0 = last_grant_q;
            grant1 = !last_grant_q;
         end else begin
            grant0 = req0;
            grant1 = req1;
         end
      end
   end

   always_comb begin
      owner_d      = owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      last_grant_d = last_grant_q;
      if (grant0) begin
         owner_d      = 1'b0;
         we_d         = 1'b0;
         addr_d       = addr0;
         wdata_d      = '0;
         last_grant_d = 1'b0;
      end else if (grant1) begin
         owner_d      = 1'b1;
         we_d         = we1;
         addr_d       = addr1;
         wdata_d      = wdata1;
         last_grant_d = 1'b1;
      end
   end

   // A write keeps the owner's rdata; an out-of-range access returns zero data.
   always_comb begin
      rvalid0_d = 1'b0;
      rvalid1_d = 1'b0;
      err0_d    = 1'b0;
      err1_d    = 1'b0;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      if (state_q == ACCESS) begin
         if (!owner_q) begin
            rvalid0_d = 1'b1;
            err0_d    = illegal;
            if (illegal) begin
               rdata0_d = '0;
            end else if (!we_q) begin
               rdata0_d = dataOut;
            end
         end else begin
            rvalid1_d = 1'b1;
            err1_d    = illegal;
            if (illegal) begin
               rdata1_d = '0;
            end else if (!we_q) begin
               rdata1_d = dataOut;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rvalid0_q    <= 1'b0;
         rvalid1_q    <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         err0_q       <= 1'b0;
         err1_q       <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rvalid0_q    <= rvalid0_d;
         rvalid1_q    <= rvalid1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         err0_q       <= err0_d;
         err1_q       <= err1_d;
      end
   end

   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;
   assign err0    = err0_q;
   assign err1    = err1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants, accesses and responses;
// a negedge monitor pops and compares them against what the DUT presents.

module tb_mem_arbiter;

   typedef struct packed {
      logic [15:0] rdata;
      logic        keep;
      logic        err;
   } resp_t;

   typedef struct packed {
      logic [15:0] addr;
      logic        we;
      logic [15:0] wdata;
   } acc_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, we1;
   logic [15:0] addr0, addr1, wdata1;
   logic        ready0, ready1, rvalid0, rvalid1, err0, err1;
   logic [15:0] rdata0, rdata1;
   logic        memRead, memWrite;
   logic [15:0] address, dataIn, dataOut;

   logic [7:0]  mem [0:127];
   bit          mem_init = 1'b0;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          grant_cycle = 0;
   int          waited;
   logic [15:0] held [2];
   logic        g_exp;
   acc_t        a_exp;

   logic        gq [$];
   acc_t        aq [$];
   resp_t       rq0 [$];
   resp_t       rq1 [$];

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_BYTES(128)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .addr0(addr0), .ready0(ready0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .ready1(ready1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
      .memRead(memRead), .memWrite(memWrite), .address(address), .dataIn(dataIn), .dataOut(dataOut)
   );

   always #5 clk = ~clk;

   // Big-endian byte memory with combinational read and clocked write.
   assign dataOut = (address < 16'd127) ? {mem[address[6:0]], mem[address[6:0] + 7'd1]} : 16'h0000;

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
         mem[8'h00] <= 8'hAB; mem[8'h01] <= 8'h99;
         mem[8'h20] <= 8'hC3; mem[8'h21] <= 8'h3C;
         mem[8'h30] <= 8'h11; mem[8'h31] <= 8'h22;
         mem[8'h40] <= 8'h33; mem[8'h41] <= 8'h44; mem[8'h42] <= 8'h55;
         mem[8'h7E] <= 8'hE2; mem[8'h7F] <= 8'hE3;
         mem_init <= 1'b1;
      end else if (memWrite && address < 16'd127) begin
         mem[address[6:0]]        <= dataIn[15:8];
         mem[address[6:0] + 7'd1] <= dataIn[7:0];
      end
   end

   task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkResetState();
      checkVal("rst_ready0", 16'(ready0), 16'h0);
      checkVal("rst_ready1", 16'(ready1), 16'h0);
      checkVal("rst_rvalid0", 16'(rvalid0), 16'h0);
      checkVal("rst_rvalid1", 16'(rvalid1), 16'h0);
      checkVal("rst_err0", 16'(err0), 16'h0);
      checkVal("rst_err1", 16'(err1), 16'h0);
      checkVal("rst_rdata0", rdata0, 16'h0);
      checkVal("rst_rdata1", rdata1, 16'h0);
      checkVal("rst_memRead", 16'(memRead), 16'h0);
      checkVal("rst_memWrite", 16'(memWrite), 16'h0);
      checkVal("rst_address", address, 16'h0);
      checkVal("rst_dataIn", dataIn, 16'h0);
   endtask

   // Compare one port's response outputs against the scoreboard for this cycle.
   task automatic checkOutput(input logic port, input logic rv, input logic [15:0] rd, input logic er);
      resp_t       e;
      logic [15:0] exp;
      logic        empty;
      checks++;
      if (rv) begin
         empty = (port == 1'b0) ? (rq0.size() == 0) : (rq1.size() == 0);
         if (empty) begin
            errors++;
            $display("[TB] FAIL resp%0d got unexpected rvalid rdata=%h err=%b, required no rvalid", port, rd, er);
         end else begin
            if (port == 1'b0) e = rq0.pop_front();
            else              e = rq1.pop_front();
            exp = e.keep ? held[port] : e.rdata;
            if (rd !== exp || er !== e.err || cyc != grant_cycle + 2) begin
               errors++;
               $display("[TB] FAIL resp%0d got rdata=%h err=%b at grant+%0d, required rdata=%h err=%b at grant+2",
                        port, rd, er, cyc - grant_cycle, exp, e.err);
            end
            held[port] = exp;
         end
      end else if (er !== 1'b0 || rd !== held[port]) begin
         errors++;
         $display("[TB] FAIL idle%0d got rdata=%h err=%b, required rdata=%h err=0", port, rd, er, held[port]);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         held[0] = 16'h0;
         held[1] = 16'h0;
      end else begin
         cyc++;
         checkOutput(1'b0, rvalid0, rdata0, err0);
         checkOutput(1'b1, rvalid1, rdata1, err1);
         if (memRead || memWrite) begin
            checks++;
            if (aq.size() == 0) begin
               errors++;
               $display("[TB] FAIL strobe got memRead=%b memWrite=%b addr=%h, required no strobe", memRead, memWrite, address);
            end else begin
               a_exp = aq.pop_front();
               if (address !== a_exp.addr || memWrite !== a_exp.we || memRead !== !a_exp.we ||
                   (a_exp.we && dataIn !== a_exp.wdata) || cyc != grant_cycle + 1) begin
                  errors++;
                  $display("[TB] FAIL access got addr=%h rd=%b wr=%b din=%h at grant+%0d, required addr=%h we=%b din=%h at grant+1",
                           address, memRead, memWrite, dataIn, cyc - grant_cycle, a_exp.addr, a_exp.we, a_exp.wdata);
               end
            end
         end
         if (ready0 || ready1) begin
            checks++;
            if (ready0 && ready1) begin
               errors++;
               $display("[TB] FAIL grant got ready0=1 ready1=1, required a single grant");
            end else if (gq.size() == 0) begin
               errors++;
               $display("[TB] FAIL grant got ready%0d, required no grant", ready1);
            end else begin
               g_exp = gq.pop_front();
               if (ready1 !== g_exp) begin
                  errors++;
                  $display("[TB] FAIL grant got port %0d, required port %0d", ready1, g_exp);
               end
            end
            grant_cycle = cyc;
         end
      end
   end

   // Issue one request, queue its expectations and hold it until accepted.
   task automatic applyStimulus(input logic port, input logic we, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [15:0] exp_rdata,
                                input logic keep, input logic exp_err, output int n_wait);
      logic  got;
      acc_t  a;
      resp_t r;
      got    = 1'b0;
      n_wait = 0;
      a.addr = addr; a.we = we; a.wdata = wdata;
      r.rdata = exp_rdata; r.keep = keep; r.err = exp_err;
      gq.push_back(port);
      if (!exp_err) aq.push_back(a);
      if (port == 1'b0) rq0.push_back(r);
      else              rq1.push_back(r);
      if (port == 1'b0) begin
         req0 = 1'b1; addr0 = addr;
      end else begin
         req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
      end
      for (int i = 1; i <= 20 && !got; i++) begin
         @(negedge clk);
         if ((port == 1'b0) ? ready0 : ready1) begin
            got    = 1'b1;
            n_wait = i;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept%0d got no ready, required ready within 20 cycles", port);
      end
      @(posedge clk); #1;
      if (port == 1'b0) req0 = 1'b0;
      else begin
         req1 = 1'b0; we1 = 1'b0;
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog got no finish, required finish before 100000 time units");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      req0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
      addr0 = 16'h0; addr1 = 16'h0; wdata1 = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      checkResetState();
      rst = 1'b0;

      $display("[TB] port 0 read with preloaded memory");
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0, 16'hAB99, 1'b0, 1'b0, waited);
      idleCycles(3);

      $display("[TB] port 1 store then load");
      applyStimulus(1'b1, 1'b1, 16'h0010, 16'h1234, 16'h0, 1'b1, 1'b0, waited);
      applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 16'h1234, 1'b0, 1'b0, waited);
      idleCycles(3);

      $display("[TB] continuous contention");
      gq.push_back(1'b0); gq.push_back(1'b1); gq.push_back(1'b0); gq.push_back(1'b1);
      aq.push_back({16'h0030, 1'b0, 16'h0}); aq.push_back({16'h0040, 1'b0, 16'h0});
      aq.push_back({16'h0030, 1'b0, 16'h0}); aq.push_back({16'h0040, 1'b0, 16'h0});
      rq0.push_back({16'h1122, 1'b0, 1'b0}); rq0.push_back({16'h1122, 1'b0, 1'b0});
      rq1.push_back({16'h3344, 1'b0, 1'b0}); rq1.push_back({16'h3344, 1'b0, 1'b0});
      req0 = 1'b1; addr0 = 16'h0030;
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0040;
      idleCycles(8);
      req0 = 1'b0; req1 = 1'b0;
      idleCycles(3);

      $display("[TB] out-of-range accesses");
      applyStimulus(1'b1, 1'b0, 16'h007F, 16'h0, 16'h0, 1'b0, 1'b1, waited);
      applyStimulus(1'b0, 1'b0, 16'h0100, 16'h0, 16'h0, 1'b0, 1'b1, waited);
      idleCycles(3);

      $display("[TB] reset during store access");
      gq.push_back(1'b1);
      aq.push_back({16'h0020, 1'b1, 16'hDEAD});
      req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0020; wdata1 = 16'hDEAD;
      @(negedge clk);
      checkVal("store_ready1", 16'(ready1), 16'h1);
      @(posedge clk); #1;
      req1 = 1'b0; we1 = 1'b0;
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      checkVal("async_memWrite", 16'(memWrite), 16'h0);
      checkVal("async_memRead", 16'(memRead), 16'h0);
      @(posedge clk); #1;
      checkResetState();
      rst = 1'b0;
      idleCycles(3);
      gq.push_back(1'b0); gq.push_back(1'b1);
      aq.push_back({16'h0020, 1'b0, 16'h0}); aq.push_back({16'h0010, 1'b0, 16'h0});
      rq0.push_back({16'hC33C, 1'b0, 1'b0});
      rq1.push_back({16'h1234, 1'b0, 1'b0});
      req0 = 1'b1; addr0 = 16'h0020;
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0010;
      idleCycles(4);
      req0 = 1'b0; req1 = 1'b0;
      idleCycles(3);

      $display("[TB] back-to-back port 0 reads");
      applyStimulus(1'b0, 1'b0, 16'h0041, 16'h0, 16'h4455, 1'b0, 1'b0, waited);
      applyStimulus(1'b0, 1'b0, 16'h007E, 16'h0, 16'hE2E3, 1'b0, 1'b0, waited);
      checkVal("b2b_accept_1", 16'(waited), 16'd2);
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0, 16'hAB99, 1'b0, 1'b0, waited);
      checkVal("b2b_accept_2", 16'(waited), 16'd2);
      idleCycles(4);

      checks++;
      if (gq.size() != 0 || aq.size() != 0 || rq0.size() != 0 || rq1.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain got grants=%0d accesses=%0d resp0=%0d resp1=%0d pending, required 0",
                  gq.size(), aq.size(), rq0.size(), rq1.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
